// File: rtl/dpram_drain.sv
// dpram_drain
//   Consumer side of the waveform-reader DPRAM handshake. Each dpram_run pulse
//   starts a transfer of dpram_len 16-bit half-words read from the 32-bit
//   event DPRAM, starting at word 0. Each word is sent high half first. The
//   half-words go out on a valid/ready stream with sop/eop marks.
//
// Ports
//   clk, rst              system clock, asynchronous active-high reset
//   dpram_run, dpram_len  start pulse and half-word count (sampled with run)
//   dpram_busy            high from the cycle after an accepted run through done
//   dpram_done            one-cycle completion pulse
//   rd_addr, rd_en        DPRAM read port (rd_data valid one cycle after rd_en)
//   rd_data               DPRAM read data
//   out_data/valid/ready  16-bit output stream
//   out_sop, out_eop      first / last half-word marks
//   err_overlap, err_len  sticky error flags, cleared by err_clr (set wins)
//   pkt_cnt               completed-transfer counter, wraps
//
// state | meaning
// IDLE  | waiting for dpram_run
// FETCH | issue DPRAM read of the current word
// LATCH | capture rd_data into the word register
// HI    | present word[31:16]
// LO    | present word[15:0]
// DONE  | pulse dpram_done, count the transfer

module dpram_drain #(
    parameter int P_ADR_WIDTH = 10,
    parameter int P_LEN_WIDTH = 16,
    parameter int P_CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dpram_run,
    input  logic [P_LEN_WIDTH-1:0] dpram_len,
    output logic                   dpram_busy,
    output logic                   dpram_done,
    output logic [P_ADR_WIDTH-1:0] rd_addr,
    output logic                   rd_en,
    input  logic [31:0]            rd_data,
    output logic [15:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic                   err_overlap,
    output logic                   err_len,
    input  logic                   err_clr,
    output logic [P_CNT_WIDTH-1:0] pkt_cnt
);

    // Capacity in half-words. One extra bit keeps the clamp value
    // representable even when dpram_len is narrow.
    localparam int                 CAP    = 2 ** (P_ADR_WIDTH + 1);
    localparam logic [P_LEN_WIDTH:0] CAP_HW = (P_LEN_WIDTH + 1)'(CAP);
    localparam logic [P_LEN_WIDTH:0] ONE_HW = (P_LEN_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_HI,
        S_LO,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [P_ADR_WIDTH-1:0] addr;
    logic [P_LEN_WIDTH:0]   remaining;
    logic [31:0]            word;
    logic                   first;

    logic [P_LEN_WIDTH:0]   len_ext;
    logic                   len_over;
    logic [P_LEN_WIDTH:0]   len_eff;
    logic                   run_ok;
    logic                   hs;
    logic                   last_hw;

    assign len_ext  = {1'b0, dpram_len};
    assign len_over = (len_ext > CAP_HW);
    assign len_eff  = len_over ? CAP_HW : len_ext;
    assign run_ok   = dpram_run && (state == S_IDLE);
    assign hs       = out_valid && out_ready;
    assign last_hw  = (remaining == ONE_HW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rd_en      = 1'b0;
        rd_addr    = '0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_sop    = 1'b0;
        out_eop    = 1'b0;
        dpram_done = 1'b0;
        dpram_busy = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (dpram_run) begin
                    state_nxt = (len_eff == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                rd_en     = 1'b1;
                rd_addr   = addr;
                state_nxt = S_LATCH;
            end
            S_LATCH: begin
                state_nxt = S_HI;
            end
            S_HI: begin
                out_valid = 1'b1;
                out_data  = word[31:16];
                out_sop   = first;
                out_eop   = last_hw;
                if (out_ready) begin
                    state_nxt = last_hw ? S_DONE : S_LO;
                end
            end
            S_LO: begin
                out_valid = 1'b1;
                out_data  = word[15:0];
                out_eop   = last_hw;
                if (out_ready) begin
                    state_nxt = last_hw ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                dpram_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr        <= '0;
            remaining   <= '0;
            word        <= '0;
            first       <= 1'b0;
            err_overlap <= 1'b0;
            err_len     <= 1'b0;
            pkt_cnt     <= '0;
        end else begin
            if (run_ok) begin
                remaining <= len_eff;
                addr      <= '0;
                first     <= 1'b1;
            end
            if (state == S_LATCH) begin
                word <= rd_data;
            end
            if (hs) begin
                remaining <= remaining - ONE_HW;
                if (state == S_HI) begin
                    first <= 1'b0;
                end
                if (state == S_LO) begin
                    addr <= addr + P_ADR_WIDTH'(1);
                end
            end
            if (state == S_DONE) begin
                pkt_cnt <= pkt_cnt + P_CNT_WIDTH'(1);
            end
            // A new error in the same cycle as err_clr keeps the flag set.
            err_overlap <= (dpram_run && (state != S_IDLE)) || (err_overlap && !err_clr);
            err_len     <= (run_ok && len_over) || (err_len && !err_clr);
        end
    end

endmodule

// File: tb/tb_dpram_drain.sv
module tb_dpram_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        dpram_run;
    logic [15:0] dpram_len;
    logic        dpram_busy;
    logic        dpram_done;
    logic [9:0]  rd_addr;
    logic        rd_en;
    logic [31:0] rd_data = '0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic        err_overlap;
    logic        err_len;
    logic        err_clr;
    logic [31:0] pkt_cnt;

    always #5 clk = ~clk;

    dpram_drain #(
        .P_ADR_WIDTH(10),
        .P_LEN_WIDTH(16),
        .P_CNT_WIDTH(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dpram_run  (dpram_run),
        .dpram_len  (dpram_len),
        .dpram_busy (dpram_busy),
        .dpram_done (dpram_done),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .err_overlap(err_overlap),
        .err_len    (err_len),
        .err_clr    (err_clr),
        .pkt_cnt    (pkt_cnt)
    );

    // DPRAM model: registered read, data one cycle after rd_en.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected stream: built from the DPRAM contents and the length rule.
    typedef struct {
        logic [15:0] d;
        logic        sop;
        logic        eop;
    } hw_t;

    hw_t         exp_q [$];
    logic [15:0] log_q [$];
    int          cyc          = 0;
    int          rd_cnt       = 0;
    int          rd_hist [1024];
    int          done_cnt     = 0;
    int          busy_cyc     = 0;
    int          last_eop_cyc = -1;
    logic        prev_stall   = 1'b0;
    logic        bp_mode      = 1'b0;
    int          bp_idx       = 0;

    function automatic void model_push(input int len);
        int leff;
        leff = (len > 2048) ? 2048 : len;
        for (int i = 0; i < leff; i++) begin
            hw_t         h;
            logic [31:0] w;
            w     = mem[i / 2];
            h.d   = (i % 2 == 0) ? w[31:16] : w[15:0];
            h.sop = (i == 0);
            h.eop = (i == leff - 1);
            exp_q.push_back(h);
        end
    endfunction

    // Compare process: checks every cycle the stream or control is meaningful.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (dpram_busy) busy_cyc++;
            if (rd_en) begin
                rd_cnt++;
                rd_hist[rd_addr]++;
            end
            if (prev_stall) check("valid_hold", 32'(out_valid), 32'd1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("data", 32'(out_data), 32'(exp_q[0].d));
                    check("sop", 32'(out_sop), 32'(exp_q[0].sop));
                    check("eop", 32'(out_eop), 32'(exp_q[0].eop));
                    if (out_ready) begin
                        log_q.push_back(out_data);
                        if (exp_q[0].eop) last_eop_cyc = cyc;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (exp_q.size() > 0) check("busy_during", 32'(dpram_busy), 32'd1);
            if (dpram_done) begin
                done_cnt++;
                check("done_q_empty", 32'(exp_q.size()), 32'd0);
                check("done_busy", 32'(dpram_busy), 32'd1);
                if (last_eop_cyc >= 0) check("done_after_eop", 32'(cyc - last_eop_cyc), 32'd1);
                last_eop_cyc = -1;
            end
            prev_stall = out_valid && !out_ready;
        end
    end

    // Ready driver: high, or 1-low/2-high when backpressure is enabled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_mode ? (bp_idx % 3 != 0) : 1'b1;
            bp_idx++;
        end
    end

    task automatic clear_stats();
        log_q.delete();
        rd_cnt   = 0;
        busy_cyc = 0;
        for (int i = 0; i < 1024; i++) rd_hist[i] = 0;
    endtask

    task automatic start(input int len);
        @(posedge clk);
        #1;
        dpram_run = 1'b1;
        dpram_len = 16'(len);
        @(posedge clk);
        #1;
        dpram_run = 1'b0;
        model_push(len);
    endtask

    task automatic pulse_run(input int len, input logic clr);
        dpram_run = 1'b1;
        dpram_len = 16'(len);
        err_clr   = clr;
        @(posedge clk);
        #1;
        dpram_run = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        int base;
        n    = 0;
        base = done_cnt;
        while (done_cnt == base && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(name, 32'(done_cnt - base), 32'd1);
    endtask

    task automatic check_stream(input string name, input int n,
                                input logic [15:0] a0, input logic [15:0] a1,
                                input logic [15:0] a2, input logic [15:0] a3);
        logic [15:0] e [4];
        e[0] = a0; e[1] = a1; e[2] = a2; e[3] = a3;
        check({name, "_len"}, 32'(log_q.size()), 32'(n));
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            check({name, "_hw"}, 32'(log_q[i]), 32'(e[i]));
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_valid"}, 32'(out_valid), 32'd0);
        check({name, "_busy"}, 32'(dpram_busy), 32'd0);
        check({name, "_done"}, 32'(dpram_done), 32'd0);
        check({name, "_rd_en"}, 32'(rd_en), 32'd0);
        check({name, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({name, "_data"}, 32'(out_data), 32'd0);
        check({name, "_sop_eop"}, 32'({out_sop, out_eop}), 32'd0);
        check({name, "_errs"}, 32'({err_overlap, err_len}), 32'd0);
        check({name, "_pkt"}, pkt_cnt, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int dsnap;

        mem[0] = 32'h1111_2222;
        mem[1] = 32'h3333_4444;
        for (int i = 2; i < 1024; i++) mem[i] = {16'hA000 | 16'(i), 16'hB000 | 16'(i)};

        rst       = 1'b1;
        dpram_run = 1'b0;
        dpram_len = '0;
        err_clr   = 1'b0;
        #1;
        check_idle_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_stats();

        // Basic transfer with latency probe.
        start(4);
        @(negedge clk);
        check("lat_fetch_rd_en", 32'(rd_en), 32'd1);
        check("lat_fetch_addr", 32'(rd_addr), 32'd0);
        check("lat_fetch_busy", 32'(dpram_busy), 32'd1);
        check("lat_fetch_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_latch_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_hi_valid", 32'(out_valid), 32'd1);
        check("lat_hi_data", 32'(out_data), 32'h1111);
        check("lat_hi_sop", 32'(out_sop), 32'd1);
        wait_done("basic_done", 50);
        check_stream("basic", 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        check("basic_pkt", pkt_cnt, 32'd1);
        check("basic_rd", 32'(rd_cnt), 32'd2);

        // Odd length.
        clear_stats();
        start(3);
        wait_done("odd_done", 50);
        check_stream("odd", 3, 16'h1111, 16'h2222, 16'h3333, 16'h0000);
        check("odd_rd", 32'(rd_cnt), 32'd2);
        check("odd_pkt", pkt_cnt, 32'd2);

        // Backpressure.
        clear_stats();
        bp_mode = 1'b1;
        start(4);
        wait_done("bp_done", 80);
        bp_mode = 1'b0;
        check_stream("bp", 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        check("bp_pkt", pkt_cnt, 32'd3);

        // Zero length.
        clear_stats();
        start(0);
        wait_done("zero_done", 20);
        check("zero_busy_cycles", 32'(busy_cyc), 32'd1);
        check("zero_stream", 32'(log_q.size()), 32'd0);
        check("zero_rd", 32'(rd_cnt), 32'd0);
        check("zero_err_len", 32'(err_len), 32'd0);
        check("zero_pkt", pkt_cnt, 32'd4);

        // Oversize length clamps to full capacity.
        clear_stats();
        start(5000);
        wait_done("big_done", 6000);
        check("big_stream", 32'(log_q.size()), 32'd2048);
        check("big_rd", 32'(rd_cnt), 32'd1024);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (rd_hist[i] != 1) bad++;
        check("big_addr_once", 32'(bad), 32'd0);
        if (log_q.size() == 2048) begin
            check("big_hw_2046", 32'(log_q[2046]), 32'hA3FF);
            check("big_hw_2047", 32'(log_q[2047]), 32'hB3FF);
        end
        check("big_err_len", 32'(err_len), 32'd1);
        check("big_pkt", pkt_cnt, 32'd5);

        // Overlap mid-transfer.
        clear_stats();
        start(4);
        @(posedge clk);
        #1;
        pulse_run(2, 1'b0);
        check("ovl_err", 32'(err_overlap), 32'd1);
        wait_done("ovl_done", 50);
        check_stream("ovl", 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        check("ovl_pkt", pkt_cnt, 32'd6);

        // Clear coinciding with a fresh overlap: overlap set wins, len clears.
        clear_stats();
        start(4);
        pulse_run(2, 1'b1);
        check("setwin_ovl", 32'(err_overlap), 32'd1);
        check("setwin_len", 32'(err_len), 32'd0);
        wait_done("setwin_done", 50);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("clr_flags", 32'({err_overlap, err_len}), 32'd0);
        check("clr_pkt", pkt_cnt, 32'd7);

        // Asynchronous reset mid-transfer.
        clear_stats();
        start(4);
        for (int n = 0; n < 50 && log_q.size() < 2; n++) @(posedge clk);
        check("rst_two_hw", 32'(log_q.size() >= 2), 32'd1);
        @(posedge clk);
        #2;
        dsnap = done_cnt;
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        exp_q.delete();
        last_eop_cyc = -1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_done", 32'(done_cnt - dsnap), 32'd0);

        clear_stats();
        start(2);
        wait_done("post_rst_done", 50);
        check_stream("post_rst", 2, 16'h1111, 16'h2222, 16'h0000, 16'h0000);
        check("post_rst_rd", 32'(rd_cnt), 32'd1);
        check("post_rst_addr0", 32'(rd_hist[0]), 32'd1);
        check("post_rst_pkt", pkt_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpram_drain.md
Name: dpram_drain

Overview:
- Consumer end of the waveform-reader DPRAM handshake. It services each `dpram_run` pulse by reading `dpram_len` 16-bit half-words out of the 1024x32 event DPRAM and streaming them on a 16-bit valid/ready interface, with start- and end-of-packet marks.
- It holds `dpram_busy` for the duration of the transfer and pulses `dpram_done` when the last half-word is accepted.
- It replaces the bench-level fake DPRAM user and feeds the downstream packetiser/transport.

Parameters:
- P_ADR_WIDTH, 10, DPRAM word address width; capacity is 2^P_ADR_WIDTH 32-bit words.
- P_LEN_WIDTH, 16, width of `dpram_len` (units: 16-bit half-words).
- P_CNT_WIDTH, 32, width of the `pkt_cnt` statistics counter.

Ports:
- clk  in  1  system clock; all logic is in this single domain.
- rst  in  1  asynchronous active-high reset.
- dpram_run  in  1  single-cycle pulse from the reader: buffer is filled and ready to drain.
- dpram_len  in  P_LEN_WIDTH  half-word count; sampled on the cycle `dpram_run` is high.
- dpram_busy  out  1  high from the cycle after an accepted run until the `dpram_done` cycle, inclusive.
- dpram_done  out  1  single-cycle pulse when the transfer completes.
- rd_addr  out  P_ADR_WIDTH  DPRAM read address.
- rd_en  out  1  DPRAM read enable.
- rd_data  in  32  DPRAM read data; valid exactly 1 cycle after `rd_en`.
- out_data  out  16  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  downstream ready.
- out_sop  out  1  marks the first half-word of a transfer.
- out_eop  out  1  marks the last half-word of a transfer.
- err_overlap  out  1  sticky: `dpram_run` arrived while busy.
- err_len  out  1  sticky: `dpram_len` exceeded capacity.
- err_clr  in  1  clears both sticky error flags.
- pkt_cnt  out  P_CNT_WIDTH  count of completed transfers; wraps on overflow.

Behaviour:
- Reset: every output is 0; the FSM is in IDLE; internal address, remaining count and word register are 0.
- Reset asserted mid-transfer aborts immediately; no `dpram_done` is issued.
- Half-word order within a DPRAM word: bits [31:16] first, then bits [15:0]. Words are read from address 0 upward.
- Length handling:
  - `len_eff = min(dpram_len, 2*2^P_ADR_WIDTH)`.
  - If `dpram_len` > 2048 (default parameters), the length is clamped to 2048 and `err_len` is set in the same cycle the run is accepted.
- FSM states: IDLE, FETCH, LATCH, HI, LO, DONE.
  - IDLE:
    - On `dpram_run` with `len_eff` = 0: go to DONE.
    - On `dpram_run` with `len_eff` > 0: `remaining = len_eff`, `addr = 0`, go to FETCH.
    - `dpram_busy` rises on the next cycle.
  - FETCH: `rd_en = 1`, `rd_addr = addr`; next state LATCH.
  - LATCH: capture `rd_data` into the word register; next state HI.
  - HI:
    - `out_valid = 1`, `out_data = word[31:16]`.
    - `out_sop = 1` if this is the first half-word of the transfer.
    - `out_eop = 1` if `remaining` = 1.
    - On `out_ready`: decrement `remaining`; if it reaches 0 go to DONE, else go to LO.
  - LO:
    - `out_valid = 1`, `out_data = word[15:0]`, `out_eop = 1` if `remaining` = 1.
    - On `out_ready`: decrement `remaining`, increment `addr`; if it reaches 0 go to DONE, else go to FETCH.
  - DONE: `dpram_done = 1` for exactly 1 cycle, `dpram_busy = 1` in this cycle, `pkt_cnt` increments; next state IDLE with `dpram_busy` = 0.
- Odd `len_eff`: the final word emits its high half only.
- Latency:
  - First `out_valid` appears 3 cycles after the cycle `dpram_run` is sampled.
  - With `out_ready` held high, throughput is 2 half-words per 4 cycles.
- Stream rules: `out_data`, `out_sop` and `out_eop` are stable while `out_valid` is high and `out_ready` is low. `out_valid` never drops without a handshake.
- Overlap: `dpram_run` while not IDLE is ignored (the transfer in progress is unaffected) and sets `err_overlap`.
- Error clear: `err_clr` clears both sticky flags. If `err_clr` and a new error occur in the same cycle, the set wins.
- `dpram_run` and DONE coinciding in the same cycle counts as overlap (busy is still high).

Test Plan:
- Basic transfer: run with len=4, DPRAM[0]=0x11112222, DPRAM[1]=0x33334444, ready held high.
  - Stream is 0x1111(sop), 0x2222, 0x3333, 0x4444(eop).
  - `dpram_done` pulses 1 cycle after the eop handshake; `pkt_cnt`=1.
- Odd length: len=3 → stream is 0x1111, 0x2222, 0x3333(eop). `rd_en` fires exactly twice.
- Backpressure: len=4 with `out_ready` toggling in a 1-low/2-high pattern.
  - Data, sop and eop hold while stalled.
  - No half-word is dropped or duplicated.
  - `dpram_busy` stays high throughout.
- Boundaries:
  - len=0 → no `out_valid`; `dpram_busy` high for 1 cycle with `dpram_done`.
  - len=5000 → exactly 2048 half-words, addresses 0..1023 each read once, `err_len`=1.
- Overlap and clear: second `dpram_run` mid-transfer → first transfer completes unchanged and `err_overlap`=1; then `err_clr` → both flags return to 0.
- Reset mid-transfer: async `rst` after 2 half-words.
  - All outputs go to 0 immediately; no `dpram_done`.
  - A following run with len=2 streams correctly from address 0.
